// File: rtl/alu_share_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | alu_share_arbiter: round-robin sharing of one combinational ALU between    |
// | two requesters, with registered operands and captured result/flags.        |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module alu_share_arbiter #(
  parameter int WIDTH = 32,
  parameter int OPW   = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0,
  input  logic             req1,
  input  logic [OPW-1:0]   op0,
  input  logic [OPW-1:0]   op1,
  input  logic [WIDTH-1:0] a0,
  input  logic [WIDTH-1:0] b0,
  input  logic [WIDTH-1:0] a1,
  input  logic [WIDTH-1:0] b1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             done0,
  output logic             done1,
  output logic [WIDTH-1:0] result,
  output logic             zout,
  output logic             vout,
  output logic             nout,
  output logic             err,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [OPW-1:0]   alu_gin,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_zout,
  input  logic             alu_vout,
  input  logic             alu_nout
);

  localparam logic [OPW-1:0] OP_ADD = OPW'(3'b010);
  localparam logic [OPW-1:0] OP_SUB = OPW'(3'b110);
  localparam logic [OPW-1:0] OP_SLT = OPW'(3'b111);
  localparam logic [OPW-1:0] OP_AND = OPW'(3'b000);
  localparam logic [OPW-1:0] OP_OR  = OPW'(3'b001);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic             ptr_q;
  logic             owner_q;
  logic             gnt0_q, gnt1_q, done0_q, done1_q;
  logic [WIDTH-1:0] result_q;
  logic             zout_q, vout_q, nout_q, err_q;
  logic [WIDTH-1:0] alu_a_q, alu_b_q;
  logic [OPW-1:0]   alu_gin_q;

  logic             win1_d;
  logic             addsub_d;
  logic             legal_d;

  // ptr_q set means requester 1 wins a tie.
  always_comb begin
    win1_d   = req1 & (~req0 | ptr_q);
    addsub_d = (alu_gin_q == OP_ADD) || (alu_gin_q == OP_SUB);
    legal_d  = addsub_d || (alu_gin_q == OP_SLT) ||
               (alu_gin_q == OP_AND) || (alu_gin_q == OP_OR);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ptr_q     <= 1'b0;
      owner_q   <= 1'b0;
      gnt0_q    <= 1'b0;
      gnt1_q    <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      result_q  <= '0;
      zout_q    <= 1'b0;
      vout_q    <= 1'b0;
      nout_q    <= 1'b0;
      err_q     <= 1'b0;
      alu_a_q   <= '0;
      alu_b_q   <= '0;
      alu_gin_q <= '0;
    end else begin
      done0_q <= 1'b0;
      done1_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req0 || req1) begin
            owner_q   <= win1_d;
            alu_gin_q <= win1_d ? op1 : op0;
            alu_a_q   <= win1_d ? a1 : a0;
            alu_b_q   <= win1_d ? b1 : b0;
            gnt0_q    <= ~win1_d;
            gnt1_q    <= win1_d;
            state_q   <= S_EXEC;
          end
        end
        S_EXEC: begin
          // Illegal codes still go through the ALU, but its outputs are discarded.
          if (legal_d) begin
            result_q <= alu_result;
            zout_q   <= alu_zout;
            nout_q   <= alu_nout;
            vout_q   <= addsub_d & alu_vout;
            err_q    <= 1'b0;
          end else begin
            result_q <= '0;
            zout_q   <= 1'b1;
            nout_q   <= 1'b0;
            vout_q   <= 1'b0;
            err_q    <= 1'b1;
          end
          done0_q <= ~owner_q;
          done1_q <= owner_q;
          state_q <= S_DONE;
        end
        S_DONE: begin
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          ptr_q   <= ~owner_q;
          state_q <= S_IDLE;
        end
        default: begin
          gnt0_q  <= 1'b0;
          gnt1_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign gnt0    = gnt0_q;
  assign gnt1    = gnt1_q;
  assign done0   = done0_q;
  assign done1   = done1_q;
  assign result  = result_q;
  assign zout    = zout_q;
  assign vout    = vout_q;
  assign nout    = nout_q;
  assign err     = err_q;
  assign alu_a   = alu_a_q;
  assign alu_b   = alu_b_q;
  assign alu_gin = alu_gin_q;

endmodule
`default_nettype wire
